interrupt_sequencer: RTL and testbench

- Takes the registered irq/vector request from the interrupt controller and turns it into the CPU interrupt entry sequence.
- Entry sequence: wait for an instruction boundary, push the return PC (two stack writes), clear SREG.I, acknowledge the source by clearing its TIFR flag, then load the vector into the PC.
- Also handles the RETI side: re-enables I and enforces one instruction executed before the next interrupt is taken.
- Sits between interrupt_controller, the CPU control unit, the data-memory write port and the SREG/TIFR/SP registers.

---
 rtl/interrupt_sequencer_pkg.sv | 26 ++
 rtl/interrupt_sequencer_if.sv | 46 ++++
 rtl/interrupt_sequencer_vector_to_tifr_mask.sv | 24 ++
 rtl/interrupt_sequencer.sv | 172 +++++++++++++++++
 tb/tb_interrupt_sequencer.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/interrupt_sequencer_pkg.sv
// Shared constants for the interrupt entry sequencer: bus widths, timer-0 ISR
// vector addresses, TIFR0 bit positions and the sequencer state encoding.
package interrupt_sequencer_pkg;

    localparam int SEQ_DATA_WIDTH   = 8;
    localparam int SEQ_I_ADDR_WIDTH = 10;
    localparam int SEQ_D_ADDR_WIDTH = 8;

    // Word addresses of the timer-0 handlers in the vector table
    localparam logic [SEQ_I_ADDR_WIDTH-1:0] TIM0_COMPA_ISR = 10'h01C;
    localparam logic [SEQ_I_ADDR_WIDTH-1:0] TIM0_COMPB_ISR = 10'h01E;
    localparam logic [SEQ_I_ADDR_WIDTH-1:0] TIM0_OVF_ISR   = 10'h020;

    localparam int TOV0  = 0;
    localparam int OCF0A = 1;
    localparam int OCF0B = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PUSH_L   = 3'd1,
        ST_PUSH_H   = 3'd2,
        ST_JUMP     = 3'd3,
        ST_COOLDOWN = 3'd4
    } seq_state_e;

endpackage

// File: rtl/interrupt_sequencer_if.sv
// Bundle of the request, CPU-boundary, stack-write and register-update signals
// around the sequencer. The master modport is the sequencer's view.
interface interrupt_sequencer_if
    import interrupt_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH   = SEQ_DATA_WIDTH,
    parameter int I_ADDR_WIDTH = SEQ_I_ADDR_WIDTH,
    parameter int D_ADDR_WIDTH = SEQ_D_ADDR_WIDTH
);

    logic                    irq;
    logic [I_ADDR_WIDTH-1:0] vector;
    logic                    instr_done;
    logic [I_ADDR_WIDTH-1:0] pc_next;
    logic                    reti;
    logic [D_ADDR_WIDTH-1:0] sp;

    logic                    stall;
    logic                    mem_wr_en;
    logic [D_ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wr_data;
    logic                    sp_wr_en;
    logic [D_ADDR_WIDTH-1:0] sp_wr_data;
    logic                    sreg_i_clr;
    logic                    sreg_i_set;
    logic [DATA_WIDTH-1:0]   tifr_clr;
    logic                    pc_load;
    logic [I_ADDR_WIDTH-1:0] pc_load_value;
    logic                    ack;
    logic [I_ADDR_WIDTH-1:0] ack_vector;

    modport master (
        input  irq, vector, instr_done, pc_next, reti, sp,
        output stall, mem_wr_en, mem_addr, mem_wr_data, sp_wr_en, sp_wr_data,
               sreg_i_clr, sreg_i_set, tifr_clr, pc_load, pc_load_value,
               ack, ack_vector
    );

    modport slave (
        output irq, vector, instr_done, pc_next, reti, sp,
        input  stall, mem_wr_en, mem_addr, mem_wr_data, sp_wr_en, sp_wr_data,
               sreg_i_clr, sreg_i_set, tifr_clr, pc_load, pc_load_value,
               ack, ack_vector
    );

endinterface

// File: rtl/interrupt_sequencer_vector_to_tifr_mask.sv
// Decodes an ISR vector into the write-1-to-clear mask for the matching TIFR0
// flag; vectors that do not belong to timer 0 produce an empty mask.
module vector_to_tifr_mask
    import interrupt_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH   = SEQ_DATA_WIDTH,
    parameter int I_ADDR_WIDTH = SEQ_I_ADDR_WIDTH
) (
    input  logic [I_ADDR_WIDTH-1:0] vector_i,
    output logic [DATA_WIDTH-1:0]   mask_o
);

    always_comb begin
        mask_o = '0;
        if (vector_i == I_ADDR_WIDTH'(TIM0_OVF_ISR)) begin
            mask_o[TOV0] = 1'b1;
        end else if (vector_i == I_ADDR_WIDTH'(TIM0_COMPA_ISR)) begin
            mask_o[OCF0A] = 1'b1;
        end else if (vector_i == I_ADDR_WIDTH'(TIM0_COMPB_ISR)) begin
            mask_o[OCF0B] = 1'b1;
        end
    end

endmodule

// File: rtl/interrupt_sequencer.sv
// CPU interrupt entry sequencer: pushes the return PC, clears SREG.I, acks the
// TIFR flag and jumps to the vector; also re-arms I on RETI with a one-instruction guard.
module interrupt_sequencer
    import interrupt_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH   = SEQ_DATA_WIDTH,
    parameter int I_ADDR_WIDTH = SEQ_I_ADDR_WIDTH,
    parameter int D_ADDR_WIDTH = SEQ_D_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    interrupt_sequencer_if.master seq_if
);

    seq_state_e              state_q, state_d;
    logic                    reti_guard_q, reti_guard_d;
    logic [I_ADDR_WIDTH-1:0] vec_q, vec_d;
    logic [I_ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [D_ADDR_WIDTH-1:0] sp_q, sp_d;

    logic                    stall_q, stall_d;
    logic                    mem_wr_en_q, mem_wr_en_d;
    logic [D_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wr_data_q, mem_wr_data_d;
    logic                    sp_wr_en_q, sp_wr_en_d;
    logic [D_ADDR_WIDTH-1:0] sp_wr_data_q, sp_wr_data_d;
    logic                    sreg_i_clr_q, sreg_i_clr_d;
    logic                    sreg_i_set_q, sreg_i_set_d;
    logic [DATA_WIDTH-1:0]   tifr_clr_q, tifr_clr_d;
    logic                    pc_load_q, pc_load_d;
    logic [I_ADDR_WIDTH-1:0] pc_load_value_q, pc_load_value_d;
    logic                    ack_q, ack_d;
    logic [I_ADDR_WIDTH-1:0] ack_vector_q, ack_vector_d;

    logic [DATA_WIDTH-1:0]   tifr_mask;

    vector_to_tifr_mask #(
        .DATA_WIDTH   (DATA_WIDTH),
        .I_ADDR_WIDTH (I_ADDR_WIDTH)
    ) u_tifr_mask (
        .vector_i (vec_d),
        .mask_o   (tifr_mask)
    );

    // RETI has priority at a boundary; the boundary right after it is never taken.
    always_comb begin
        state_d      = state_q;
        reti_guard_d = reti_guard_q;
        vec_d        = vec_q;
        pc_d         = pc_q;
        sp_d         = sp_q;
        sreg_i_set_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (seq_if.instr_done) begin
                    if (seq_if.reti) begin
                        sreg_i_set_d = 1'b1;
                        reti_guard_d = 1'b1;
                    end else if (reti_guard_q) begin
                        reti_guard_d = 1'b0;
                    end else if (seq_if.irq) begin
                        vec_d   = seq_if.vector;
                        pc_d    = seq_if.pc_next;
                        sp_d    = seq_if.sp;
                        state_d = ST_PUSH_L;
                    end
                end
            end
            ST_PUSH_L:   state_d = ST_PUSH_H;
            ST_PUSH_H:   state_d = ST_JUMP;
            ST_JUMP:     state_d = ST_COOLDOWN;
            ST_COOLDOWN: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear registered in that state.
    always_comb begin
        stall_d         = (state_d != ST_IDLE);
        mem_wr_en_d     = 1'b0;
        mem_addr_d      = '0;
        mem_wr_data_d   = '0;
        sp_wr_en_d      = 1'b0;
        sp_wr_data_d    = '0;
        sreg_i_clr_d    = 1'b0;
        tifr_clr_d      = '0;
        pc_load_d       = 1'b0;
        pc_load_value_d = '0;
        ack_d           = 1'b0;
        ack_vector_d    = '0;
        case (state_d)
            ST_PUSH_L: begin
                mem_wr_en_d   = 1'b1;
                mem_addr_d    = sp_d;
                mem_wr_data_d = pc_d[DATA_WIDTH-1:0];
            end
            ST_PUSH_H: begin
                mem_wr_en_d   = 1'b1;
                mem_addr_d    = sp_d - D_ADDR_WIDTH'(1);
                mem_wr_data_d = DATA_WIDTH'(pc_d >> DATA_WIDTH);
            end
            ST_JUMP: begin
                pc_load_d       = 1'b1;
                pc_load_value_d = vec_d;
                sp_wr_en_d      = 1'b1;
                sp_wr_data_d    = sp_d - D_ADDR_WIDTH'(2);
                sreg_i_clr_d    = 1'b1;
                ack_d           = 1'b1;
                ack_vector_d    = vec_d;
                tifr_clr_d      = tifr_mask;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            reti_guard_q    <= 1'b0;
            vec_q           <= '0;
            pc_q            <= '0;
            sp_q            <= '0;
            stall_q         <= 1'b0;
            mem_wr_en_q     <= 1'b0;
            mem_addr_q      <= '0;
            mem_wr_data_q   <= '0;
            sp_wr_en_q      <= 1'b0;
            sp_wr_data_q    <= '0;
            sreg_i_clr_q    <= 1'b0;
            sreg_i_set_q    <= 1'b0;
            tifr_clr_q      <= '0;
            pc_load_q       <= 1'b0;
            pc_load_value_q <= '0;
            ack_q           <= 1'b0;
            ack_vector_q    <= '0;
        end else begin
            state_q         <= state_d;
            reti_guard_q    <= reti_guard_d;
            vec_q           <= vec_d;
            pc_q            <= pc_d;
            sp_q            <= sp_d;
            stall_q         <= stall_d;
            mem_wr_en_q     <= mem_wr_en_d;
            mem_addr_q      <= mem_addr_d;
            mem_wr_data_q   <= mem_wr_data_d;
            sp_wr_en_q      <= sp_wr_en_d;
            sp_wr_data_q    <= sp_wr_data_d;
            sreg_i_clr_q    <= sreg_i_clr_d;
            sreg_i_set_q    <= sreg_i_set_d;
            tifr_clr_q      <= tifr_clr_d;
            pc_load_q       <= pc_load_d;
            pc_load_value_q <= pc_load_value_d;
            ack_q           <= ack_d;
            ack_vector_q    <= ack_vector_d;
        end
    end

    assign seq_if.stall         = stall_q;
    assign seq_if.mem_wr_en     = mem_wr_en_q;
    assign seq_if.mem_addr      = mem_addr_q;
    assign seq_if.mem_wr_data   = mem_wr_data_q;
    assign seq_if.sp_wr_en      = sp_wr_en_q;
    assign seq_if.sp_wr_data    = sp_wr_data_q;
    assign seq_if.sreg_i_clr    = sreg_i_clr_q;
    assign seq_if.sreg_i_set    = sreg_i_set_q;
    assign seq_if.tifr_clr      = tifr_clr_q;
    assign seq_if.pc_load       = pc_load_q;
    assign seq_if.pc_load_value = pc_load_value_q;
    assign seq_if.ack           = ack_q;
    assign seq_if.ack_vector    = ack_vector_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench for interrupt_sequencer: directed scenarios followed by
// random instruction boundaries checked against a boundary-count model.
module tb_interrupt_sequencer;
    import interrupt_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    interrupt_sequencer_if bus ();

    interrupt_sequencer dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .seq_if (bus)
    );

    int testsRun    = 0;
    int testsFailed = 0;
    // Boundaries completed since the last RETI; an interrupt needs at least one.
    int bndSinceReti = 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic int expMask(input logic [9:0] v);
        if (v == TIM0_OVF_ISR)   return 1 << TOV0;
        if (v == TIM0_COMPA_ISR) return 1 << OCF0A;
        if (v == TIM0_COMPB_ISR) return 1 << OCF0B;
        return 0;
    endfunction

    task automatic scrambleDontCares();
        bus.vector  = 10'($urandom);
        bus.pc_next = 10'($urandom);
        bus.sp      = 8'($urandom);
    endtask

    // Presents one instruction boundary, returns at the negedge of the following cycle.
    task automatic applyStimulus(input logic irqV, input logic retiV, input logic [9:0] vecV,
                                 input logic [9:0] pcV, input logic [7:0] spV);
        bus.instr_done = 1'b1;
        bus.irq        = irqV;
        bus.reti       = retiV;
        bus.vector     = vecV;
        bus.pc_next    = pcV;
        bus.sp         = spV;
        @(negedge clk);
        bus.instr_done = 1'b0;
        bus.reti       = 1'b0;
    endtask

    task automatic checkEntry(input logic [9:0] vec, input logic [9:0] pc, input logic [7:0] spv);
        int pcInt = int'(pc);
        int spInt = int'(spv);
        int acks  = 0;
        scrambleDontCares();
        checkOutput("pushL_stall", bus.stall, 1);
        checkOutput("pushL_wr", bus.mem_wr_en, 1);
        checkOutput("pushL_addr", bus.mem_addr, spInt);
        checkOutput("pushL_data", bus.mem_wr_data, pcInt % 256);
        checkOutput("pushL_spwr", bus.sp_wr_en, 0);
        checkOutput("pushL_iset", bus.sreg_i_set, 0);
        acks += int'(bus.ack);
        @(negedge clk);
        scrambleDontCares();
        checkOutput("pushH_wr", bus.mem_wr_en, 1);
        checkOutput("pushH_addr", bus.mem_addr, (spInt + 255) % 256);
        checkOutput("pushH_data", bus.mem_wr_data, pcInt / 256);
        checkOutput("pushH_pcload", bus.pc_load, 0);
        acks += int'(bus.ack);
        @(negedge clk);
        scrambleDontCares();
        checkOutput("jump_stall", bus.stall, 1);
        checkOutput("jump_wr", bus.mem_wr_en, 0);
        checkOutput("jump_pcload", bus.pc_load, 1);
        checkOutput("jump_pcval", bus.pc_load_value, vec);
        checkOutput("jump_spwr", bus.sp_wr_en, 1);
        checkOutput("jump_spdata", bus.sp_wr_data, (spInt + 254) % 256);
        checkOutput("jump_iclr", bus.sreg_i_clr, 1);
        checkOutput("jump_ackvec", bus.ack_vector, vec);
        checkOutput("jump_tifr", bus.tifr_clr, expMask(vec));
        acks += int'(bus.ack);
        @(negedge clk);
        checkOutput("cool_stall", bus.stall, 1);
        checkOutput("cool_pcload", bus.pc_load, 0);
        checkOutput("cool_tifr", bus.tifr_clr, 0);
        checkOutput("cool_iclr", bus.sreg_i_clr, 0);
        acks += int'(bus.ack);
        @(negedge clk);
        checkOutput("idle_stall", bus.stall, 0);
        acks += int'(bus.ack);
        checkOutput("ack_count", acks, 1);
    endtask

    task automatic checkNoEntry(input logic expSet);
        checkOutput("noentry_stall", bus.stall, 0);
        checkOutput("noentry_wr", bus.mem_wr_en, 0);
        checkOutput("noentry_ack", bus.ack, 0);
        checkOutput("noentry_iset", bus.sreg_i_set, expSet);
    endtask

    task automatic boundaryStep(input logic irqV, input logic retiV, input logic [9:0] vecV,
                                input logic [9:0] pcV, input logic [7:0] spV);
        logic expEntry;
        expEntry = irqV && !retiV && (bndSinceReti >= 1);
        if (retiV) bndSinceReti = 0;
        else if (bndSinceReti < 1000) bndSinceReti++;
        applyStimulus(irqV, retiV, vecV, pcV, spV);
        if (expEntry) checkEntry(vecV, pcV, spV);
        else checkNoEntry(retiV);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [9:0] vecR;
        rst_n          = 1'b0;
        bus.irq        = 1'b0;
        bus.reti       = 1'b0;
        bus.instr_done = 1'b0;
        bus.vector     = '0;
        bus.pc_next    = '0;
        bus.sp         = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_stall", bus.stall, 0);
        checkOutput("rst_wr", bus.mem_wr_en, 0);
        checkOutput("rst_ack", bus.ack, 0);
        checkOutput("rst_pcload", bus.pc_load, 0);
        checkOutput("rst_tifr", bus.tifr_clr, 0);
        checkOutput("rst_iset", bus.sreg_i_set, 0);
        rst_n = 1'b1;
        @(negedge clk);

        boundaryStep(1'b1, 1'b0, TIM0_OVF_ISR, 10'h2A5, 8'hDF);
        bus.irq = 1'b0;

        // RETI with a pending irq, then the guarded instruction, then entry
        boundaryStep(1'b1, 1'b1, TIM0_COMPA_ISR, 10'h100, 8'h80);
        boundaryStep(1'b1, 1'b0, TIM0_COMPA_ISR, 10'h101, 8'h80);
        boundaryStep(1'b1, 1'b0, TIM0_COMPA_ISR, 10'h102, 8'h80);

        // Stale irq held through cooldown, then earliest re-entry
        boundaryStep(1'b1, 1'b0, TIM0_COMPB_ISR, 10'h033, 8'hF0);
        boundaryStep(1'b1, 1'b0, TIM0_COMPB_ISR, 10'h034, 8'hF0);
        @(negedge clk);
        checkOutput("stale_idle_stall", bus.stall, 0);
        checkOutput("stale_idle_ack", bus.ack, 0);
        bus.irq = 1'b0;

        boundaryStep(1'b1, 1'b0, TIM0_COMPA_ISR, 10'h1FF, 8'h01);
        boundaryStep(1'b1, 1'b0, 10'h003, 10'h155, 8'h40);

        // Reset while the high byte is being pushed
        applyStimulus(1'b1, 1'b0, TIM0_OVF_ISR, 10'h0AA, 8'hC0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_stall", bus.stall, 0);
        checkOutput("midrst_wr", bus.mem_wr_en, 0);
        checkOutput("midrst_addr", bus.mem_addr, 0);
        checkOutput("midrst_data", bus.mem_wr_data, 0);
        checkOutput("midrst_spwr", bus.sp_wr_en, 0);
        checkOutput("midrst_pcload", bus.pc_load, 0);
        checkOutput("midrst_ack", bus.ack, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bndSinceReti = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("postrst_stall", bus.stall, 0);
            checkOutput("postrst_spwr", bus.sp_wr_en, 0);
        end
        boundaryStep(1'b1, 1'b0, TIM0_OVF_ISR, 10'h0AB, 8'hC0);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0: vecR = TIM0_OVF_ISR;
                1: vecR = TIM0_COMPA_ISR;
                2: vecR = TIM0_COMPB_ISR;
                default: vecR = 10'($urandom);
            endcase
            boundaryStep(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                         vecR, 10'($urandom), 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
